// File: rtl/cdc_xfer_arbiter_if.sv
// Bundle of the requester-side and CDC-channel signals of cdc_xfer_arbiter.
// The slave modport is taken by the arbiter; the master modport is the
// requester / far-side view. With CDC_TIMEOUT_EN defined the bundle also
// carries the abort pulse vector and the sticky timeout flag.
interface cdc_xfer_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 16
);
  localparam int unsigned SW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   done;
  logic [W-1:0]       xfer_data;
  logic [SW-1:0]      xfer_src;
  logic               xfer_toggle;
  logic               ack_toggle;
  logic               busy;
`ifdef CDC_TIMEOUT_EN
  logic [N_REQ-1:0]   abort;
  logic               timeout_err;

  modport slave (
    input  req, req_data, ack_toggle,
    output done, xfer_data, xfer_src, xfer_toggle, busy, abort, timeout_err
  );

  modport master (
    output req, req_data, ack_toggle,
    input  done, xfer_data, xfer_src, xfer_toggle, busy, abort, timeout_err
  );
`else
  modport slave (
    input  req, req_data, ack_toggle,
    output done, xfer_data, xfer_src, xfer_toggle, busy
  );

  modport master (
    output req, req_data, ack_toggle,
    input  done, xfer_data, xfer_src, xfer_toggle, busy
  );
`endif
endinterface

// File: rtl/cdc_xfer_arbiter.sv
// Source-domain arbiter sharing one multi-bit CDC channel among N_REQ
// requesters with a toggle req/ack handshake. Round-robin grant, word held
// on xfer_data for a full cycle before xfer_toggle flips, completion when
// the synchronized ack_toggle matches xfer_toggle again.
// Optional feature macro: CDC_TIMEOUT_EN (WAIT_ACK timeout with abort pulse
// and sticky timeout_err).
module cdc_xfer_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  cdc_xfer_arbiter_if.slave bus
);

  localparam int unsigned SW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  // Reject unsupported configurations at elaboration time.
  if (N_REQ < 2 || N_REQ > 8 || GAP > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("cdc_xfer_arbiter: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StWaitAck,
    StGap
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [W-1:0]     xfer_data_q, xfer_data_d;
  logic [SW-1:0]    xfer_src_q, xfer_src_d;
  logic             xfer_toggle_q, xfer_toggle_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
`ifdef CDC_TIMEOUT_EN
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [N_REQ-1:0] abort_q, abort_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  logic             quiescent;
  logic             win_valid;
  logic [SW-1:0]    win_idx;
  int unsigned      cand;
  logic [SW-1:0]    next_ptr;
  state_e           post_state;

  // No transfer is outstanding while both toggles agree.
  assign quiescent = (bus.ack_toggle == xfer_toggle_q);

  // Round-robin search: first active request at or above rr_ptr, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr_q) + k) % N_REQ;
      if (!win_valid && bus.req[cand[SW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[SW-1:0];
      end
    end
  end

  // Pointer and state shared by the completion and abort paths.
  always_comb begin
    next_ptr   = (xfer_src_q == SW'(N_REQ - 1)) ? '0 : xfer_src_q + 1'b1;
    post_state = (GAP == 0) ? StIdle : StGap;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    done_d        = '0;
    xfer_data_d   = xfer_data_q;
    xfer_src_d    = xfer_src_q;
    xfer_toggle_d = xfer_toggle_q;
    rr_ptr_d      = rr_ptr_q;
    gap_cnt_d     = gap_cnt_q;
`ifdef CDC_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    abort_d       = '0;
    timeout_err_d = timeout_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // A stale or spurious ack mismatch holds off any new launch.
        if (|bus.req && quiescent) state_d = StLoad;
      end
      StLoad: begin
        if (win_valid) begin
          xfer_data_d = bus.req_data[32'(win_idx) * W +: W];
          xfer_src_d  = win_idx;
          state_d     = StLaunch;
        end else begin
          // Request vanished between IDLE and LOAD; just go back.
          state_d = StIdle;
        end
      end
      StLaunch: begin
        xfer_toggle_d = ~xfer_toggle_q;
        state_d       = StWaitAck;
`ifdef CDC_TIMEOUT_EN
        to_cnt_d      = '0;
`endif
      end
      StWaitAck: begin
`ifdef CDC_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 1'b1;
`endif
        if (quiescent) begin
          done_d[xfer_src_q] = 1'b1;
          rr_ptr_d           = next_ptr;
          state_d            = post_state;
          gap_cnt_d          = 4'(GAP - 1);
        end
`ifdef CDC_TIMEOUT_EN
        else if (to_cnt_d == TW'(TIMEOUT)) begin
          abort_d[xfer_src_q] = 1'b1;
          timeout_err_d       = 1'b1;
          rr_ptr_d            = next_ptr;
          state_d             = post_state;
          gap_cnt_d           = 4'(GAP - 1);
        end
`endif
      end
      StGap: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State register with synchronous reset; reset drops any transfer silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      done_q        <= '0;
      xfer_data_q   <= '0;
      xfer_src_q    <= '0;
      xfer_toggle_q <= 1'b0;
      busy_q        <= 1'b0;
      rr_ptr_q      <= '0;
      gap_cnt_q     <= '0;
`ifdef CDC_TIMEOUT_EN
      to_cnt_q      <= '0;
      abort_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      xfer_data_q   <= xfer_data_d;
      xfer_src_q    <= xfer_src_d;
      xfer_toggle_q <= xfer_toggle_d;
      busy_q        <= busy_d;
      rr_ptr_q      <= rr_ptr_d;
      gap_cnt_q     <= gap_cnt_d;
`ifdef CDC_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      abort_q       <= abort_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.done        = done_q;
  assign bus.xfer_data   = xfer_data_q;
  assign bus.xfer_src    = xfer_src_q;
  assign bus.xfer_toggle = xfer_toggle_q;
  assign bus.busy        = busy_q;
`ifdef CDC_TIMEOUT_EN
  assign bus.abort       = abort_q;
  assign bus.timeout_err = timeout_err_q;
`endif

endmodule

// File: doc/cdc_xfer_arbiter.md
Name: cdc_xfer_arbiter

Overview:
- Source-domain controller that shares one multi-bit clock-domain-crossing channel among N requesters, using a toggle req/ack handshake.
- Arbitrates round-robin and holds the winner's word stable on `xfer_data`, then flips `xfer_toggle`.
- Waits for the returned `ack_toggle` to match, then releases the requester.
- The synchronizer stages themselves are external: `xfer_toggle` is synchronized into the far domain, and `ack_toggle` arrives already synchronized into `clk`.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 16, data word width.
- GAP, 2, idle cycles enforced after each completed transfer (0..15).
- TIMEOUT, 255, max WAIT_ACK cycles before abort (used only with CDC_TIMEOUT_EN).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held until matching done/abort.
- req_data  input  N_REQ*W  packed words; requester i uses bits [i*W +: W]; held stable while req[i]=1.
- done  output  N_REQ  one-cycle pulse: requester's word acknowledged by far side.
- xfer_data  output  W  word presented to the CDC channel; registered.
- xfer_src  output  clog2(N_REQ)  index of current/last winner; registered.
- xfer_toggle  output  1  transfer request toggle; registered.
- ack_toggle  input  1  far-side ack toggle, already synchronized to clk.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: done=0, xfer_data=0, xfer_src=0, xfer_toggle=0, busy=0, state=IDLE, rr_ptr=0, gap counter=0. Reset mid-transfer aborts silently (no done). The far side must be reset in the same event so that ack_toggle returns to 0.
- Channel quiescent ⇔ ack_toggle == xfer_toggle.
- States:
  - IDLE → LOAD when any req bit=1 and channel quiescent. Otherwise stay.
  - LOAD (1 cycle):
    - Winner = first requester with req=1, searching from rr_ptr upward with wrap at N_REQ-1 → 0.
    - xfer_data ← winner's word; xfer_src ← winner.
    - → LAUNCH.
  - LAUNCH (1 cycle): xfer_toggle ← ~xfer_toggle. Data has therefore been stable ≥1 cycle before the toggle edge. → WAIT_ACK.
  - WAIT_ACK: when ack_toggle == xfer_toggle:
    - done[xfer_src] pulses for 1 cycle.
    - rr_ptr ← (xfer_src+1) mod N_REQ.
    - → GAP, or → IDLE if GAP=0.
  - GAP: count GAP cycles, then → IDLE.
- xfer_data and xfer_src are unchanged from LOAD until the next LOAD.
- Minimum latency, req rise to done: 3 cycles + far-side round trip. The earliest next LOAD is GAP+1 cycles after done.
- A requester that drops req after LOAD is still serviced; its done pulse is still issued. Dropping req early is a protocol violation but must not hang the block.
- A req rising during LOAD/LAUNCH/WAIT_ACK/GAP waits for the next arbitration.
- Simultaneous requests: the winner is strictly determined by rr_ptr. With all requests asserted, the grant order is 0,1,2,…,N_REQ-1,0 (fair).
- A spurious ack_toggle change in IDLE/GAP causes no done. It only blocks launch until the channel is quiescent again.
- The requester deasserts req on the cycle after done; a req still high at the next IDLE is treated as a new request.

Optional Feature:
- Macro: CDC_TIMEOUT_EN.
- Enabled:
  - A WAIT_ACK cycle counter (clog2(TIMEOUT+1) bits), cleared in LAUNCH.
  - When it reaches TIMEOUT without a matching ack:
    - output `abort` (N_REQ wide) pulses on bit xfer_src; done is not pulsed.
    - sticky output `timeout_err` (1 bit) is set; cleared only by rst.
    - rr_ptr advances as for done; state → GAP.
  - A late ack later restores quiescence; the IDLE gating prevents a false done.
- Disabled: abort and timeout_err ports do not exist. WAIT_ACK waits indefinitely.

Test Plan:
- Single request: N_REQ=4, W=16, GAP=2, far-side model acks 4 cycles after toggle. req[2]=1, word 0xBEEF → xfer_data=0xBEEF and xfer_src=2 after LOAD; xfer_toggle 0→1 in LAUNCH; done[2] pulses once; busy high throughout; ≥2 idle cycles before next LOAD.
- Fairness: all req=1 with words 0x1111..0x4444, held through 8 transfers → done order 0,1,2,3,0,1,2,3; xfer_toggle alternates each transfer; xfer_data never changes within a WAIT_ACK.
- Late arrival: req[3] rises while transfer for requester 1 is in WAIT_ACK; req[0] also high → next grant is 3 (rr_ptr=2), then 0.
- Non-quiescent channel: force ack_toggle≠xfer_toggle in IDLE with req[0]=1 → no LOAD and no done until ack_toggle matches; then a normal transfer completes.
- Reset mid-transfer: assert rst in WAIT_ACK → next cycle all outputs are at reset values; no done pulse; a new req[1] after reset completes normally.
- Timeout (CDC_TIMEOUT_EN, TIMEOUT=10): far side never acks → abort[xfer_src] pulses on WAIT_ACK cycle 10; timeout_err=1 and stays high; no done; new requests are blocked until the late ack arrives.
